dkm_buyer: RTL and testbench
============================

DKM_BUYER -- requirements
Module: dkm_buyer

Interface
REQ-001 Parameter WAIT_MAX, default 8: cycles allowed after the final coin gap for DISPENSE before timeout (range 1..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-003 CLK  in  1  clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset; asynchronous, active-high.
REQ-005 START  in  1  purchase request, sampled only in IDLE.
REQ-006 N_CNT, D_CNT, Q_CNT  in  4 each  nickels, dimes and quarters to insert; latched on an accepted START.
REQ-007 EMPTY, DISPENSE, NICKEL_OUT, DIME_OUT, TWO_DIME_OUT, USE_EXACT  in  1 each  drink-machine status and change outputs.
REQ-008 NICKEL_IN, DIME_IN, QUARTER_IN  out  1 each  coin pulses to the drink machine.
REQ-009 BUSY  out  1  purchase in progress.
REQ-010 DONE  out  1  one-cycle completion pulse.
REQ-011 GOT_CAN  out  1  a can was dispensed in the last purchase.
REQ-012 TIMEOUT  out  1  the last purchase ended without DISPENSE.
REQ-013 REJECTED  out  1  the last START was refused because EMPTY=1.
REQ-014 PAID  out  8  cents inserted in the last or current purchase.
REQ-015 CHANGE  out  8  cents of change returned in the last purchase.
REQ-016 EXACT_SEEN  out  1  USE_EXACT was 1 when START was accepted.

Function
REQ-017 States: IDLE, FEED, GAP, WAIT, FIN; all outputs SHALL be registered.
REQ-018 IDLE + START=1 + EMPTY=1 -> FIN, with REJECTED=1, no coin pulses and PAID=0.
REQ-019 IDLE + START=1 + EMPTY=0 -> latch counts, clear PAID/CHANGE/GOT_CAN/TIMEOUT/REJECTED, capture EXACT_SEEN, set BUSY=1, go to FEED (or to WAIT if all counts are 0).
REQ-020 Coin order SHALL be all nickels, then dimes, then quarters.
REQ-021 FEED: exactly one coin output high for exactly one cycle, then GAP for one cycle with all coin outputs low.
REQ-022 After GAP, the next coin goes to FEED; after the last coin, go to WAIT.
REQ-023 The first coin pulse SHALL be high in the cycle immediately after the accepting edge.
REQ-024 On each coin pulse, PAID increments by 5, 10 or 25 with saturation at 255; the maximum legal total is 600, so saturation is required.
REQ-025 At most one of NICKEL_IN, DIME_IN and QUARTER_IN SHALL be high in any cycle.
REQ-026 DISPENSE=1, sampled in FEED, GAP or WAIT -> capture CHANGE = 5*NICKEL_OUT + 10*DIME_OUT + 20*TWO_DIME_OUT from the same cycle, set GOT_CAN=1, stop remaining coins and go to FIN.
REQ-027 A coin pulse already high when DISPENSE is sampled SHALL still complete and still count in PAID.
REQ-028 WAIT counts cycles from 0; reaching WAIT_MAX without DISPENSE -> TIMEOUT=1, GOT_CAN=0, CHANGE=0, go to FIN.
REQ-029 FIN: DONE=1 for exactly one cycle, BUSY=0, then IDLE.
REQ-030 Result outputs SHALL hold until the next accepted START.
REQ-031 START while not in IDLE SHALL be ignored and not queued.
REQ-032 Change outputs while DISPENSE=0 SHALL be ignored.
REQ-033 If DISPENSE and the WAIT_MAX limit occur in the same cycle, DISPENSE wins.

Reset
REQ-034 While RST=1 the block SHALL be in IDLE, with all outputs 0, counters 0 and latched counts 0.
REQ-035 RST asserted mid-purchase SHALL immediately force every coin output low.
REQ-036 The first START SHALL be accepted at the first rising edge after RST falls.

Verification
REQ-037 EMPTY=0, counts (0,0,2), machine asserts DISPENSE one cycle after the 2nd quarter -> 2 QUARTER_IN pulses with 1-cycle gaps, PAID=50, GOT_CAN=1, CHANGE=0, DONE pulses once.
REQ-038 Counts (0,3,1), DISPENSE with NICKEL_OUT=1 -> pulse order D,D,D,Q, PAID=55, CHANGE=5.
REQ-039 Counts (1,1,2), DISPENSE with NICKEL_OUT=1 and DIME_OUT=1 -> PAID=65, CHANGE=15; a repeat with TWO_DIME_OUT=1 only -> CHANGE=20.
REQ-040 EMPTY=1 at START -> no coin pulses, REJECTED=1, DONE one cycle later, GOT_CAN=0.
REQ-041 Counts (0,0,1), no DISPENSE -> TIMEOUT=1 exactly WAIT_MAX cycles after WAIT entry, PAID=25, CHANGE=0.
REQ-042 RST pulsed during the 2nd coin pulse -> coin output low immediately, all outputs 0, next START runs normally; START during BUSY -> no effect.

Source files
------------

// File: rtl/dkm_buyer.sv
// Vending-machine buyer: feeds latched nickel/dime/quarter counts to a drink machine
// one pulse at a time, then records dispense, change, timeout or rejection results.
module dkm_buyer #(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] N_CNT,
  input  logic [3:0] D_CNT,
  input  logic [3:0] Q_CNT,
  input  logic       EMPTY,
  input  logic       DISPENSE,
  input  logic       NICKEL_OUT,
  input  logic       DIME_OUT,
  input  logic       TWO_DIME_OUT,
  input  logic       USE_EXACT,
  output logic       NICKEL_IN,
  output logic       DIME_IN,
  output logic       QUARTER_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       GOT_CAN,
  output logic       TIMEOUT,
  output logic       REJECTED,
  output logic [7:0] PAID,
  output logic [7:0] CHANGE,
  output logic       EXACT_SEEN
);

  // state | meaning
  // IDLE  | waiting for START
  // FEED  | one coin pulse is high this cycle
  // GAP   | all coin outputs low between pulses
  // WAIT  | all coins sent, waiting up to WAIT_MAX cycles for DISPENSE
  // FIN   | DONE pulse, results final
  typedef enum logic [2:0] {IDLE, FEED, GAP, WAIT, FIN} state_t;

  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_MAX - 1);

  state_t     state, state_nxt;
  logic [3:0] n_left, d_left, q_left, n_left_nxt, d_left_nxt, q_left_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       nickel_nxt, dime_nxt, quarter_nxt;
  logic       busy_nxt, done_nxt, got_can_nxt, timeout_nxt, rejected_nxt, exact_nxt;
  logic [7:0] paid_nxt, change_nxt;

  logic [3:0] src_n, src_d, src_q;
  logic       have_coin, pick_n, pick_d, pick_q;
  logic [7:0] coin_val, paid_base, paid_sat, change_val;
  logic [8:0] paid_sum;

  // In IDLE the next coin is chosen from the inputs being latched, otherwise from what is left.
  assign src_n     = (state == IDLE) ? N_CNT : n_left;
  assign src_d     = (state == IDLE) ? D_CNT : d_left;
  assign src_q     = (state == IDLE) ? Q_CNT : q_left;
  assign have_coin = (src_n != 4'd0) || (src_d != 4'd0) || (src_q != 4'd0);
  assign pick_n    = (src_n != 4'd0);
  assign pick_d    = !pick_n && (src_d != 4'd0);
  assign pick_q    = !pick_n && !pick_d && (src_q != 4'd0);
  assign coin_val  = pick_n ? 8'd5 : (pick_d ? 8'd10 : 8'd25);
  assign paid_base = (state == IDLE) ? 8'd0 : PAID;
  assign paid_sum  = {1'b0, paid_base} + {1'b0, coin_val};
  assign paid_sat  = paid_sum[8] ? 8'hFF : paid_sum[7:0];
  assign change_val = (NICKEL_OUT ? 8'd5 : 8'd0) + (DIME_OUT ? 8'd10 : 8'd0)
                    + (TWO_DIME_OUT ? 8'd20 : 8'd0);

  always_comb begin
    state_nxt    = state;
    n_left_nxt   = n_left;
    d_left_nxt   = d_left;
    q_left_nxt   = q_left;
    wait_cnt_nxt = wait_cnt;
    nickel_nxt   = 1'b0;
    dime_nxt     = 1'b0;
    quarter_nxt  = 1'b0;
    busy_nxt     = BUSY;
    done_nxt     = 1'b0;
    got_can_nxt  = GOT_CAN;
    timeout_nxt  = TIMEOUT;
    rejected_nxt = REJECTED;
    exact_nxt    = EXACT_SEEN;
    paid_nxt     = PAID;
    change_nxt   = CHANGE;

    case (state)
      IDLE: begin
        if (START) begin
          paid_nxt    = 8'd0;
          change_nxt  = 8'd0;
          got_can_nxt = 1'b0;
          timeout_nxt = 1'b0;
          if (EMPTY) begin
            rejected_nxt = 1'b1;
            done_nxt     = 1'b1;
            state_nxt    = FIN;
          end else begin
            rejected_nxt = 1'b0;
            exact_nxt    = USE_EXACT;
            busy_nxt     = 1'b1;
            n_left_nxt   = N_CNT;
            d_left_nxt   = D_CNT;
            q_left_nxt   = Q_CNT;
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      FEED: state_nxt = GAP;
      GAP: begin
        state_nxt    = WAIT;
        wait_cnt_nxt = WAIT_LOAD;
      end
      WAIT: begin
        if (wait_cnt == 8'd0) begin
          timeout_nxt = 1'b1;
          got_can_nxt = 1'b0;
          change_nxt  = 8'd0;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          state_nxt   = FIN;
        end else begin
          wait_cnt_nxt = wait_cnt - 8'd1;
        end
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Issue the next coin when starting or leaving a gap; this overrides the WAIT entry above.
    if (((state == IDLE) && START && !EMPTY) || ((state == GAP) && !DISPENSE)) begin
      if (have_coin) begin
        nickel_nxt  = pick_n;
        dime_nxt    = pick_d;
        quarter_nxt = pick_q;
        n_left_nxt  = src_n - {3'b000, pick_n};
        d_left_nxt  = src_d - {3'b000, pick_d};
        q_left_nxt  = src_q - {3'b000, pick_q};
        paid_nxt    = paid_sat;
        state_nxt   = FEED;
      end
    end

    // DISPENSE wins over a coincident WAIT timeout.
    if (DISPENSE && ((state == FEED) || (state == GAP) || (state == WAIT))) begin
      change_nxt   = change_val;
      got_can_nxt  = 1'b1;
      timeout_nxt  = 1'b0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b1;
      nickel_nxt   = 1'b0;
      dime_nxt     = 1'b0;
      quarter_nxt  = 1'b0;
      state_nxt    = FIN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      n_left     <= 4'd0;
      d_left     <= 4'd0;
      q_left     <= 4'd0;
      wait_cnt   <= 8'd0;
      NICKEL_IN  <= 1'b0;
      DIME_IN    <= 1'b0;
      QUARTER_IN <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      GOT_CAN    <= 1'b0;
      TIMEOUT    <= 1'b0;
      REJECTED   <= 1'b0;
      EXACT_SEEN <= 1'b0;
      PAID       <= 8'd0;
      CHANGE     <= 8'd0;
    end else begin
      state      <= state_nxt;
      n_left     <= n_left_nxt;
      d_left     <= d_left_nxt;
      q_left     <= q_left_nxt;
      wait_cnt   <= wait_cnt_nxt;
      NICKEL_IN  <= nickel_nxt;
      DIME_IN    <= dime_nxt;
      QUARTER_IN <= quarter_nxt;
      BUSY       <= busy_nxt;
      DONE       <= done_nxt;
      GOT_CAN    <= got_can_nxt;
      TIMEOUT    <= timeout_nxt;
      REJECTED   <= rejected_nxt;
      EXACT_SEEN <= exact_nxt;
      PAID       <= paid_nxt;
      CHANGE     <= change_nxt;
    end
  end

endmodule

// File: tb/tb_dkm_buyer.sv
// Randomized bench for dkm_buyer; expectations come from a purchase-level timeline model
// (coin k high in cycle 2k after the accepting edge, DONE in the cycle after the deciding one).
module tb_dkm_buyer;

  localparam int WM = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START, EMPTY, DISPENSE, NICKEL_OUT, DIME_OUT, TWO_DIME_OUT, USE_EXACT;
  logic [3:0] N_CNT, D_CNT, Q_CNT;
  logic       NICKEL_IN, DIME_IN, QUARTER_IN, BUSY, DONE, GOT_CAN, TIMEOUT, REJECTED, EXACT_SEEN;
  logic [7:0] PAID, CHANGE;

  int checks = 0;
  int failures = 0;

  int m_paid, m_change, m_got, m_to, m_rej, m_exact;

  dkm_buyer #(.WAIT_MAX(WM)) dut (
    .CLK(CLK), .RST(RST), .START(START), .N_CNT(N_CNT), .D_CNT(D_CNT), .Q_CNT(Q_CNT),
    .EMPTY(EMPTY), .DISPENSE(DISPENSE), .NICKEL_OUT(NICKEL_OUT), .DIME_OUT(DIME_OUT),
    .TWO_DIME_OUT(TWO_DIME_OUT), .USE_EXACT(USE_EXACT), .NICKEL_IN(NICKEL_IN),
    .DIME_IN(DIME_IN), .QUARTER_IN(QUARTER_IN), .BUSY(BUSY), .DONE(DONE),
    .GOT_CAN(GOT_CAN), .TIMEOUT(TIMEOUT), .REJECTED(REJECTED), .PAID(PAID),
    .CHANGE(CHANGE), .EXACT_SEEN(EXACT_SEEN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({NICKEL_IN, DIME_IN, QUARTER_IN, BUSY, DONE, GOT_CAN, TIMEOUT,
                 REJECTED, EXACT_SEEN, PAID, CHANGE});
  endfunction

  task automatic chk_results(input string tag);
    chk({tag, "_paid"}, int'(PAID), m_paid);
    chk({tag, "_change"}, int'(CHANGE), m_change);
    chk({tag, "_got_can"}, int'(GOT_CAN), m_got);
    chk({tag, "_timeout"}, int'(TIMEOUT), m_to);
    chk({tag, "_rejected"}, int'(REJECTED), m_rej);
    chk({tag, "_exact"}, int'(EXACT_SEEN), m_exact);
  endtask

  // Called at a negedge; START is presented for the following rising edge.
  task automatic run_purchase(input int n, input int d, input int q, input int dc,
                              input logic cn, input logic cd, input logic ct,
                              input logic empty, input logic uexact, input int rst_at);
    int code[$];
    int val[$];
    int ncoin, limit, e, sum;
    bit disp_ok;
    code.delete();
    val.delete();
    if (!empty) begin
      for (int k = 0; k < n; k++) begin code.push_back(1); val.push_back(5);  end
      for (int k = 0; k < d; k++) begin code.push_back(2); val.push_back(10); end
      for (int k = 0; k < q; k++) begin code.push_back(4); val.push_back(25); end
    end
    ncoin   = code.size();
    limit   = 2 * ncoin + WM;
    disp_ok = !empty && dc >= 0 && dc < limit;
    e       = empty ? 0 : (disp_ok ? dc + 1 : limit);
    sum = 0;
    for (int k = 0; k < ncoin; k++) if (2 * k < e) sum += val[k];
    m_paid   = (sum > 255) ? 255 : sum;
    m_change = disp_ok ? (cn ? 5 : 0) + (cd ? 10 : 0) + (ct ? 20 : 0) : 0;
    m_got    = disp_ok ? 1 : 0;
    m_to     = (!empty && !disp_ok) ? 1 : 0;
    m_rej    = empty ? 1 : 0;
    if (!empty) m_exact = uexact ? 1 : 0;

    START = 1'b1; EMPTY = empty; USE_EXACT = uexact; DISPENSE = 1'b0;
    N_CNT = 4'(n); D_CNT = 4'(d); Q_CNT = 4'(q);
    for (int c = 0; c <= e; c++) begin
      @(negedge CLK);
      chk("coin", int'({QUARTER_IN, DIME_IN, NICKEL_IN}),
          (c < e && c % 2 == 0 && c / 2 < ncoin) ? code[c / 2] : 0);
      chk("done", int'(DONE), (c == e) ? 1 : 0);
      chk("busy", int'(BUSY), (!empty && c < e) ? 1 : 0);
      if (c == e) chk_results("fin");
      if (c == rst_at) begin
        RST = 1'b1;
        #1;
        chk("rst_async", all_outs(), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_held", all_outs(), 0);
        RST = 1'b0; START = 1'b0; DISPENSE = 1'b0;
        m_paid = 0; m_change = 0; m_got = 0; m_to = 0; m_rej = 0; m_exact = 0;
        return;
      end
      START        = (c < e) ? 1'($urandom_range(0, 1)) : 1'b0;
      EMPTY        = 1'($urandom_range(0, 1));
      USE_EXACT    = 1'($urandom_range(0, 1));
      N_CNT        = 4'($urandom_range(0, 15));
      DISPENSE     = (c == dc && c < e) ? 1'b1 : 1'b0;
      NICKEL_OUT   = (c == dc) ? cn : 1'($urandom_range(0, 1));
      DIME_OUT     = (c == dc) ? cd : 1'($urandom_range(0, 1));
      TWO_DIME_OUT = (c == dc) ? ct : 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("idle_coin", int'({QUARTER_IN, DIME_IN, NICKEL_IN}), 0);
      chk("idle_done", int'(DONE), 0);
      chk_results("hold");
    end
  endtask

  initial begin
    int n, d, q, lim, dc;
    RST = 1'b1; START = 1'b0; EMPTY = 1'b0; DISPENSE = 1'b0; USE_EXACT = 1'b0;
    NICKEL_OUT = 1'b0; DIME_OUT = 1'b0; TWO_DIME_OUT = 1'b0;
    N_CNT = 4'd0; D_CNT = 4'd0; Q_CNT = 4'd0;
    m_paid = 0; m_change = 0; m_got = 0; m_to = 0; m_rej = 0; m_exact = 0;
    repeat (2) @(negedge CLK);
    chk("reset_outs", all_outs(), 0);
    RST = 1'b0;

    run_purchase(0, 0, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    run_purchase(0, 3, 1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_purchase(1, 1, 2, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_purchase(1, 1, 2, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    run_purchase(2, 2, 2, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    run_purchase(0, 0, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_purchase(0, 1, 0, 2 + WM - 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_purchase(0, 0, 0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    run_purchase(15, 15, 15, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_purchase(0, 2, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    run_purchase(0, 2, 0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    for (int t = 0; t < 40; t++) begin
      n   = $urandom_range(0, 4);
      d   = $urandom_range(0, 4);
      q   = $urandom_range(0, 4);
      lim = 2 * (n + d + q) + WM;
      dc  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, lim + 2));
      run_purchase(n, d, q, dc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
